// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment capture path: segment patterns (g..a, active low),
// anode codes and the settle/hold state encoding. No logic, no latency, no backpressure.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    localparam logic [3:0] AN_DIGIT0 = 4'b1110;
    localparam logic [3:0] AN_DIGIT1 = 4'b0111;
    localparam logic [3:0] AN_DIGIT2 = 4'b1011;
    localparam logic [3:0] AN_DIGIT3 = 4'b1101;
    localparam logic [3:0] AN_IDLE   = 4'b1111;

    typedef enum logic {
        SETTLE = 1'b0,
        HELD   = 1'b1
    } cap_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps an active-low g..a segment pattern back to a BCD digit or blank, flagging unknown patterns.
// Purely combinational, zero latency, no backpressure.
module seg_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_valid,
    output logic [3:0] o_value
);

    always_comb begin
        o_valid = 1'b1;
        o_value = DIGIT_BLANK;
        case (i_pattern)
            SEG_0:     o_value = 4'd0;
            SEG_1:     o_value = 4'd1;
            SEG_2:     o_value = 4'd2;
            SEG_3:     o_value = 4'd3;
            SEG_4:     o_value = 4'd4;
            SEG_5:     o_value = 4'd5;
            SEG_6:     o_value = 4'd6;
            SEG_7:     o_value = 4'd7;
            SEG_8:     o_value = 4'd8;
            SEG_9:     o_value = 4'd9;
            SEG_BLANK: o_value = DIGIT_BLANK;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples the multiplexed seg/an bus, captures each slot once it has been stable, and publishes whole frames.
// Latency: SYNC_STAGES sync + STABLE_CYCLES settle + 1 output register; no backpressure (free-running observer).
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic [3:0] an_in,
    input  logic       err_clr,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_valid,
    output logic       frame_pulse,
    output logic       pattern_err
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [10:0] r_sync [SYNC_STAGES];
    logic [10:0] r_prev;
    logic [7:0]  r_count;
    cap_state_t  r_state;
    logic [3:0]  r_shadow [4];
    logic [3:0]  r_digit  [4];
    logic [3:0]  r_seen;
    logic        r_frame_valid;
    logic        r_frame_pulse;
    logic        r_pattern_err;

    logic [10:0] w_pair;
    logic [3:0]  w_an;
    logic        w_changed;
    logic        w_capture;
    logic        w_dec_vld;
    logic [3:0]  w_dec_val;
    logic        w_onecold;
    logic [1:0]  w_idx;
    logic        w_write;
    logic        w_err_event;
    logic [3:0]  w_seen_nxt;
    logic [3:0]  w_shadow_nxt [4];
    logic        w_unused_dp;

    // dp carries no digit information and is deliberately not sampled
    assign w_unused_dp = seg_in[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
        end else begin
            r_sync[0] <= {an_in, seg_in[6:0]};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_pair    = r_sync[SYNC_STAGES-1];
    assign w_an      = w_pair[10:7];
    assign w_changed = (w_pair != r_prev);
    assign w_capture = (r_state == SETTLE) && !w_changed && (r_count == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SETTLE;
            r_count <= '0;
            r_prev  <= '1;
        end else begin
            r_prev <= w_pair;
            if (w_changed) begin
                r_state <= SETTLE;
                r_count <= '0;
            end else if (r_state == SETTLE) begin
                if (r_count == CNT_LAST) r_state <= HELD;
                else                     r_count <= r_count + 8'd1;
            end
        end
    end

    seg_pattern_decode u_decode (
        .i_pattern (w_pair[6:0]),
        .o_valid   (w_dec_vld),
        .o_value   (w_dec_val)
    );

    always_comb begin
        w_onecold = 1'b1;
        w_idx     = 2'd0;
        case (w_an)
            AN_DIGIT0: w_idx = 2'd0;
            AN_DIGIT1: w_idx = 2'd1;
            AN_DIGIT2: w_idx = 2'd2;
            AN_DIGIT3: w_idx = 2'd3;
            default:   w_onecold = 1'b0;
        endcase
    end

    assign w_write     = w_capture && w_onecold && w_dec_vld;
    assign w_err_event = w_capture && (w_onecold ? !w_dec_vld : (w_an != AN_IDLE));
    assign w_seen_nxt  = r_seen | (w_write ? (4'b0001 << w_idx) : 4'b0000);

    // the completing capture is written through so the frame includes it
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_write) w_shadow_nxt[w_idx] = w_dec_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= DIGIT_BLANK;
                r_digit[i]  <= DIGIT_BLANK;
            end
            r_seen        <= '0;
            r_frame_valid <= 1'b0;
            r_frame_pulse <= 1'b0;
            r_pattern_err <= 1'b0;
        end else begin
            r_shadow      <= w_shadow_nxt;
            r_frame_pulse <= 1'b0;
            if (w_seen_nxt == 4'b1111) begin
                r_digit       <= w_shadow_nxt;
                r_seen        <= '0;
                r_frame_pulse <= 1'b1;
                r_frame_valid <= 1'b1;
            end else begin
                r_seen <= w_seen_nxt;
            end
            if (w_err_event)  r_pattern_err <= 1'b1;
            else if (err_clr) r_pattern_err <= 1'b0;
        end
    end

    assign digit0      = r_digit[0];
    assign digit1      = r_digit[1];
    assign digit2      = r_digit[2];
    assign digit3      = r_digit[3];
    assign frame_valid = r_frame_valid;
    assign frame_pulse = r_frame_pulse;
    assign pattern_err = r_pattern_err;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: drives slot patterns on the seg/an bus and checks
// the published frame, strobe count and sticky error against hand-computed values.
module tb_seven_segment_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_in;
    logic [3:0] an_in;
    logic       err_clr;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, frame_pulse, pattern_err;

    int n_checks;
    int n_fail;
    int pulse_cnt;

    seven_segment_capture #(.STABLE_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .err_clr     (err_clr),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .frame_valid (frame_valid),
        .frame_pulse (frame_pulse),
        .pattern_err (pattern_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_pulse) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0:       seg7 = 7'b1000000;
            1:       seg7 = 7'b1111001;
            2:       seg7 = 7'b0100100;
            3:       seg7 = 7'b0110000;
            4:       seg7 = 7'b0011001;
            5:       seg7 = 7'b0010010;
            6:       seg7 = 7'b0000010;
            7:       seg7 = 7'b1111000;
            8:       seg7 = 7'b0000000;
            9:       seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        an_in  = an;
        seg_in = {$urandom_range(0, 1) == 1, seg};
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        show(4'b1111, 7'b1111111, cycles);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_cnt = 0;
        @(negedge clk);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pulse_cnt = 0;
        rst_n     = 1'b0;
        err_clr   = 1'b0;
        an_in     = 4'b1111;
        seg_in    = 8'hFF;
        @(negedge clk);

        check("rst_digit0", digit0, 4'hF);
        check("rst_digit1", digit1, 4'hF);
        check("rst_digit2", digit2, 4'hF);
        check("rst_digit3", digit3, 4'hF);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_pulse", frame_pulse, 1'b0);
        check("rst_err", pattern_err, 1'b0);
        do_reset();

        // static scan 1,2,3,4
        show(4'b1110, seg7(1), 24);
        show(4'b0111, seg7(2), 24);
        show(4'b1011, seg7(3), 24);
        show(4'b1101, seg7(4), 24);
        idle(24);
        check("scan_pulses", pulse_cnt, 1);
        check("scan_d0", digit0, 4'd1);
        check("scan_d1", digit1, 4'd2);
        check("scan_d2", digit2, 4'd3);
        check("scan_d3", digit3, 4'd4);
        check("scan_valid", frame_valid, 1'b1);
        check("scan_err", pattern_err, 1'b0);

        // glitch on digit0 must not mark it seen
        do_reset();
        show(4'b1110, seg7(8), 10);
        idle(30);
        show(4'b0111, seg7(1), 20);
        show(4'b1011, seg7(2), 20);
        show(4'b1101, seg7(3), 20);
        idle(24);
        check("glitch_nopulse", pulse_cnt, 0);
        check("glitch_novalid", frame_valid, 1'b0);
        check("glitch_d0", digit0, 4'hF);
        show(4'b1110, seg7(8), 20);
        idle(24);
        check("glitch_pulse", pulse_cnt, 1);
        check("glitch_d0_cap", digit0, 4'd8);
        check("glitch_d1", digit1, 4'd1);
        check("glitch_d3", digit3, 4'd3);

        // blank digit2 within a frame
        show(4'b1110, seg7(5), 24);
        show(4'b0111, seg7(6), 24);
        show(4'b1011, seg7(15), 24);
        show(4'b1101, seg7(7), 24);
        idle(24);
        check("blank_pulse", pulse_cnt, 2);
        check("blank_d0", digit0, 4'd5);
        check("blank_d1", digit1, 4'd6);
        check("blank_d2", digit2, 4'hF);
        check("blank_d3", digit3, 4'd7);
        check("blank_err", pattern_err, 1'b0);

        // invalid pattern on digit0: error, and digit0 stays unseen
        show(4'b1110, 7'b1010101, 24);
        idle(24);
        check("bad_err", pattern_err, 1'b1);
        clear_err();
        check("bad_clr", pattern_err, 1'b0);
        show(4'b0111, seg7(1), 24);
        show(4'b1011, seg7(2), 24);
        show(4'b1101, seg7(3), 24);
        idle(24);
        check("bad_noseen", pulse_cnt, 2);
        show(4'b1110, seg7(9), 24);
        idle(24);
        check("bad_then_pulse", pulse_cnt, 3);
        check("bad_then_d0", digit0, 4'd9);

        // err_clr in the very cycle the error is captured: error wins
        an_in  = 4'b1110;
        seg_in = {1'b1, 7'b1010101};
        repeat (18) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        idle(24);
        check("coincident_err", pattern_err, 1'b1);
        clear_err();

        // two anodes low
        show(4'b0110, seg7(1), 24);
        idle(24);
        check("multi_err", pattern_err, 1'b1);
        check("multi_nopulse", pulse_cnt, 3);
        clear_err();

        // idle anodes with garbage segments: never captured
        show(4'b1110, seg7(4), 24);
        show(4'b1111, 7'b1010101, 30);
        check("idle_noerr", pattern_err, 1'b0);
        check("idle_nopulse", pulse_cnt, 3);

        // reset mid-frame discards partial progress
        do_reset();
        show(4'b1110, seg7(1), 24);
        show(4'b0111, seg7(2), 24);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        show(4'b1011, seg7(3), 24);
        show(4'b1101, seg7(4), 24);
        idle(24);
        check("midrst_nopulse", pulse_cnt, 0);
        check("midrst_valid", frame_valid, 1'b0);
        check("midrst_d2", digit2, 4'hF);
        check("midrst_d3", digit3, 4'hF);

        // driver-style continuous scan of 9,0,5,7
        do_reset();
        for (int s = 0; s < 3; s++) begin
            show(4'b1110, seg7(9), 24);
            show(4'b0111, seg7(0), 24);
            show(4'b1011, seg7(5), 24);
            show(4'b1101, seg7(7), 24);
        end
        idle(24);
        check("loop_pulses", pulse_cnt, 3);
        check("loop_d0", digit0, 4'd9);
        check("loop_d1", digit1, 4'd0);
        check("loop_d2", digit2, 4'd5);
        check("loop_d3", digit3, 4'd7);
        check("loop_err", pattern_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side counterpart of the seven-segment scan driver: samples the multiplexed active-low `seg`/`an` bus, waits for each anode slot to settle, decodes the segment pattern back to a BCD digit and reassembles all four digits into a coherent frame. It sits in the self-check path, where it lets the maze top and the bench read back what the display is actually showing. It runs on the fast system clock, far above the scan rate.

## Interface
Parameters:
- `STABLE_CYCLES`, 16: consecutive `clk` cycles a synchronized (`an`,`seg`) pair must hold unchanged before capture; legal range 2..255.
- `SYNC_STAGES`, 2: synchronizer depth on `seg_in`/`an_in`; minimum 2.

Ports:
- `clk` input 1: system clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `seg_in` input 8: segment bus, active low, bit6..0 = g..a; bit7 (dp) ignored.
- `an_in` input 4: anode bus, active low.
- `err_clr` input 1: clears `pattern_err`.
- `digit0`..`digit3` output 4 each: last complete frame; 0–9 = digit, 4'hF = blank.
- `frame_valid` output 1: high once at least one complete frame has been captured.
- `frame_pulse` output 1: one-cycle strobe when `digit0..3` update.
- `pattern_err` output 1: sticky; unrecognized segment pattern or multiple anodes low.

## Operation
- Anode-to-digit map: `an`=1110 → digit0, 0111 → digit1, 1011 → digit2, 1101 → digit3. `an`=1111 means idle and is never captured.
- Segment decode, on 7 bits g..a: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 1111111=blank (4'hF). Any other pattern is an error.
- State machine on the synchronized pair:
  - SETTLE: the counter increments each cycle while the pair is unchanged. Any change restarts the count at 0 and stays in SETTLE. When the count reaches `STABLE_CYCLES`-1, capture and go to HELD.
  - HELD: no further captures. Any change goes to SETTLE with the count at 0.
- Capture:
  - Anode one-cold and pattern valid: write the decoded value to that digit's shadow register and set its `seen` bit.
  - Anode one-cold and pattern invalid: set `pattern_err`. Shadow and `seen` are unchanged.
  - Two or more anodes low: set `pattern_err`.
  - Anode 1111: no action.
- Re-capturing a digit whose `seen` bit is already set overwrites its shadow, with no error.
- Frame completion: when `seen` becomes 4'b1111, including the capture that sets the last bit, copy the shadows (that capture written through) to `digit0..3`, pulse `frame_pulse`, set `frame_valid`, and clear `seen`.
- `err_clr` and a new error in the same cycle: the error wins and `pattern_err` stays 1.

## Timing
- Reset values: `digit0..3`=4'hF, `frame_valid`=0, `frame_pulse`=0, `pattern_err`=0, `seen`=0, shadows=4'hF, state=SETTLE, count=0, synchronizers=all ones.
- Reset mid-frame discards partial `seen`/shadows. Capture restarts from SETTLE after release.
- Latency:
  - A pin change reaches the comparator after `SYNC_STAGES` edges.
  - Capture occurs `STABLE_CYCLES` cycles after the synchronized change.
  - `digit*`/`frame_pulse`/`pattern_err` are registered and change on the edge after the capture cycle.
- Count width is 8 bits and does not wrap: it holds at `STABLE_CYCLES`-1 in HELD.
- Glitches shorter than `STABLE_CYCLES` cycles are never captured.

## Structure
- Package `seven_segment_pkg` holds:
  - the 11 segment pattern constants and `DIGIT_BLANK`=4'hF;
  - the four anode codes;
  - the state enum {SETTLE, HELD}.
- One sub-module, `seg_pattern_decode`: combinational, 7-bit pattern → {valid, 4-bit value}. The driver's bench reuses it.
- The synchronizer is inline, with no separate module.

## Test plan
- Static scan: hold each of the four anodes ≥ `STABLE_CYCLES`+4 cycles showing 1,2,3,4 → single `frame_pulse`; digit0..3 = 1,2,3,4; `frame_valid`=1; `pattern_err`=0.
- Glitch reject: with `STABLE_CYCLES`=16, drive `an`=1110 / seg 8 for 10 cycles, then revert → no capture, `seen` unchanged; the same pattern held 20 cycles → captured.
- Blank and bad pattern: seg 1111111 on digit2 → digit2=4'hF after frame. Seg 1010101 → `pattern_err`=1, `err_clr` pulse → 0; `err_clr` coincident with a new error → stays 1.
- Multi-anode: `an`=0110 held stable → `pattern_err`=1, no shadow write. `an`=1111 held → no capture, no error.
- Reset mid-frame: capture digits 0 and 1, assert `rst_n` low for 1 cycle, then capture 2 and 3 only → no `frame_pulse`, outputs stay 4'hF, `frame_valid`=0.
- Driver loopback: connect the scan driver with digits 9,0,5,7 → every complete scan yields `frame_pulse` with digit0..3 = 9,0,5,7, and `pattern_err` never set.
